// File: rtl/mux_8_to_1.sv
// ----------------------------------------------------------------------------
// mux_8_to_1
//
// Purpose:
//   Registered 8:1 multiplexer with an active-high enable. It picks one of
//   eight packed WIDTH-bit lanes using the select code {s2, s1, s0}. The
//   selected lane appears on y one clock later. y_valid is a registered copy
//   of en, so it is aligned with y.
//
// Build option:
//   MUX_8_TO_1_HOLD_EN
//     Undefined (default): y clears to 0 on any edge where en = 0.
//     Defined:             y holds its last value while en = 0.
//   In both builds y_valid follows en, and reset clears y to 0.
//
// Parameters:
//   WIDTH    bit width of each lane and of y
//
// Ports:
//   clk      in   1          rising-edge clock
//   rst_n    in   1          synchronous reset, active low
//   s0       in   1          select bit 0 (LSB)
//   s1       in   1          select bit 1
//   s2       in   1          select bit 2 (MSB)
//   x        in   8*WIDTH    packed lanes; lane i is x[i*WIDTH +: WIDTH]
//   en       in   1          enable, active high
//   y        out  WIDTH      registered selected lane
//   y_valid  out  1          registered copy of en
// ----------------------------------------------------------------------------
module mux_8_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s0,
  input  logic                 s1,
  input  logic                 s2,
  input  logic [8*WIDTH-1:0]   x,
  input  logic                 en,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid
);

  logic [WIDTH-1:0] w_lane [8];
  logic [2:0]       w_sel;
  logic [WIDTH-1:0] w_y_next;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;

  // Unpack the flat lane bus so the select becomes a plain array index.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign w_lane[gi] = x[gi*WIDTH +: WIDTH];
  end

  assign w_sel = {s2, s1, s0};

  always_comb begin
`ifdef MUX_8_TO_1_HOLD_EN
    w_y_next = r_y;
`else
    w_y_next = '0;
`endif
    if (en) begin
      w_y_next = w_lane[w_sel];
    end
  end

  // Reset takes priority over en and select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_y     <= w_y_next;
      r_valid <= en;
    end
  end

  assign y       = r_y;
  assign y_valid = r_valid;

endmodule

// File: tb/tb_mux_8_to_1.sv
// ----------------------------------------------------------------------------
// tb_mux_8_to_1
//
// Purpose:
//   Self-checking bench for mux_8_to_1. It builds two instances: WIDTH = 1
//   and WIDTH = 4. The stimulus tasks apply one directed vector per clock and
//   push the hand-computed response into a per-instance queue. A monitor
//   pops each queue one cycle later and compares the entry with y and
//   y_valid.
// ----------------------------------------------------------------------------
module tb_mux_8_to_1;

`ifdef MUX_8_TO_1_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] y;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 1 instance
  logic        a_rst_n, a_s0, a_s1, a_s2, a_en;
  logic [7:0]  a_x;
  logic        a_y, a_y_valid;

  // WIDTH = 4 instance
  logic        b_rst_n, b_s0, b_s1, b_s2, b_en;
  logic [31:0] b_x;
  logic [3:0]  b_y;
  logic        b_y_valid;

  mux_8_to_1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(a_rst_n), .s0(a_s0), .s1(a_s1), .s2(a_s2),
    .x(a_x), .en(a_en), .y(a_y), .y_valid(a_y_valid)
  );

  mux_8_to_1 #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(b_rst_n), .s0(b_s0), .s1(b_s1), .s2(b_s2),
    .x(b_x), .en(b_en), .y(b_y), .y_valid(b_y_valid)
  );

  exp_t q1[$];
  exp_t q4[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id1  = 0;
  int   vec_id4  = 0;

  task automatic step1(input logic rst, input logic [2:0] sel, input logic [7:0] xv,
                       input logic e, input logic ey, input logic ev);
    exp_t ex;
    @(negedge clk);
    a_rst_n = rst;
    {a_s2, a_s1, a_s0} = sel;
    a_x = xv;
    a_en = e;
    ex.y = {3'b000, ey};
    ex.v = ev;
    q1.push_back(ex);
    @(posedge clk);
  endtask

  task automatic step4(input logic rst, input logic [2:0] sel, input logic [31:0] xv,
                       input logic e, input logic [3:0] ey, input logic ev);
    exp_t ex;
    @(negedge clk);
    b_rst_n = rst;
    {b_s2, b_s1, b_s0} = sel;
    b_x = xv;
    b_en = e;
    ex.y = ey;
    ex.v = ev;
    q4.push_back(ex);
    @(posedge clk);
  endtask

  // Monitor: compare each instance's outputs shortly after each edge.
  always @(posedge clk) begin
    exp_t e1;
    exp_t e4;
    #1;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      n_checks++;
      if (a_y !== e1.y[0] || a_y_valid !== e1.v) begin
        n_fail++;
        $display("FAIL w1_vec%0d: got y=%b y_valid=%b, expected y=%b y_valid=%b",
                 vec_id1, a_y, a_y_valid, e1.y[0], e1.v);
      end else begin
        $display("ok   w1_vec%0d: y=%b y_valid=%b", vec_id1, a_y, a_y_valid);
      end
      vec_id1++;
    end
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      n_checks++;
      if (b_y !== e4.y || b_y_valid !== e4.v) begin
        n_fail++;
        $display("FAIL w4_vec%0d: got y=%h y_valid=%b, expected y=%h y_valid=%b",
                 vec_id4, b_y, b_y_valid, e4.y, e4.v);
      end else begin
        $display("ok   w4_vec%0d: y=%h y_valid=%b", vec_id4, b_y, b_y_valid);
      end
      vec_id4++;
    end
  end

  initial begin
    a_rst_n = 1'b0; {a_s2, a_s1, a_s0} = 3'd0; a_x = '0; a_en = 1'b0;
    b_rst_n = 1'b0; {b_s2, b_s1, b_s0} = 3'd0; b_x = '0; b_en = 1'b0;

    // Reset held for two edges with active-looking inputs, then release.
    step1(1'b0, 3'd3, 8'hFF, 1'b1, 1'b0, 1'b0);
    step1(1'b0, 3'd3, 8'hFF, 1'b1, 1'b0, 1'b0);
    step1(1'b1, 3'd3, 8'hFF, 1'b1, 1'b1, 1'b1);

    // Exhaustive select over 8'b10100101.
    step1(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd1, 8'hA5, 1'b1, 1'b0, 1'b1);
    step1(1'b1, 3'd2, 8'hA5, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd3, 8'hA5, 1'b1, 1'b0, 1'b1);
    step1(1'b1, 3'd4, 8'hA5, 1'b1, 1'b0, 1'b1);
    step1(1'b1, 3'd5, 8'hA5, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd6, 8'hA5, 1'b1, 1'b0, 1'b1);
    step1(1'b1, 3'd7, 8'hA5, 1'b1, 1'b1, 1'b1);

    // Single-hot lanes at both ends of the bus.
    step1(1'b1, 3'd7, 8'h80, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd0, 8'h80, 1'b1, 1'b0, 1'b1);
    step1(1'b1, 3'd0, 8'h01, 1'b1, 1'b1, 1'b1);

    // All-ones sweep.
    step1(1'b1, 3'd0, 8'hFF, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd1, 8'hFF, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd2, 8'hFF, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd3, 8'hFF, 1'b1, 1'b1, 1'b1);

    // Disable window: the previous y was 1.
    step1(1'b1, 3'd4, 8'hFF, 1'b0, HOLD, 1'b0);
    step1(1'b1, 3'd5, 8'hFF, 1'b0, HOLD, 1'b0);

    // Re-enable.
    step1(1'b1, 3'd4, 8'hFF, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd5, 8'hFF, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd6, 8'hFF, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 3'd7, 8'hFF, 1'b1, 1'b1, 1'b1);

    // Mid-stream reset clears even with en = 1.
    step1(1'b0, 3'd7, 8'hFF, 1'b1, 1'b0, 1'b0);
    step1(1'b1, 3'd7, 8'hFF, 1'b1, 1'b1, 1'b1);

    // WIDTH = 4 instance.
    step4(1'b0, 3'd6, 32'h76543210, 1'b1, 4'h0, 1'b0);
    step4(1'b1, 3'd6, 32'h76543210, 1'b1, 4'h6, 1'b1);
    step4(1'b0, 3'd6, 32'h76543210, 1'b1, 4'h0, 1'b0);
    step4(1'b1, 3'd2, 32'h76543210, 1'b1, 4'h2, 1'b1);
    step4(1'b1, 3'd7, 32'h76543210, 1'b1, 4'h7, 1'b1);
    step4(1'b1, 3'd1, 32'h76543210, 1'b0, HOLD ? 4'h7 : 4'h0, 1'b0);
    step4(1'b1, 3'd5, 32'hA5C3E10F, 1'b1, 4'hC, 1'b1);
    step4(1'b1, 3'd0, 32'hA5C3E10F, 1'b1, 4'hF, 1'b1);

    // Let the monitor drain the last entries, with a bounded wait.
    for (int i = 0; i < 4 && (q1.size() > 0 || q4.size() > 0); i++) begin
      @(posedge clk);
      #2;
    end
    if (q1.size() > 0 || q4.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d entries left in the queues, expected 0/0",
               q1.size(), q4.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
